// File: rtl/response_checker.sv
// Response checker for ISCAS85 circuits under test: compares each accepted response
// against an expected-vector memory, counts mismatches, records the first failing index
// and compacts every response into a MISR signature.
module response_checker #(
    parameter int                   OUT_WIDTH  = 8,
    parameter int                   VEC_LENGTH = 4,
    parameter int                   IDX_W      = 16,
    parameter logic [OUT_WIDTH-1:0] MISR_POLY  = 8'hB8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 exp_we,
    input  logic [IDX_W-1:0]     exp_addr,
    input  logic [OUT_WIDTH-1:0] exp_data,
    input  logic                 start,
    input  logic                 resp_valid,
    input  logic [OUT_WIDTH-1:0] resp_data,
    output logic                 resp_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [IDX_W-1:0]     err_count,
    output logic [IDX_W-1:0]     first_err_idx,
    output logic                 first_err_valid,
    output logic [OUT_WIDTH-1:0] signature
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LENGTH - 1);

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     idx;
    logic [OUT_WIDTH-1:0] mem [VEC_LENGTH];
    logic [OUT_WIDTH-1:0] exp_vec;
    logic                 handshake;
    logic                 clear_run;
    logic                 mismatch;
    logic [OUT_WIDTH-1:0] misr_next;

    always_comb begin
        state_next = state;
        resp_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        clear_run  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    clear_run  = 1'b1;
                end
            end
            RUN: begin
                resp_ready = 1'b1;
                busy       = 1'b1;
                if (resp_valid && (idx == LAST_IDX)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = RUN;
                    clear_run  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Decoded loops keep every access inside the array whatever idx/exp_addr hold.
    always_comb begin
        exp_vec = '0;
        for (int i = 0; i < VEC_LENGTH; i++) begin
            if (idx == IDX_W'(i)) begin
                exp_vec = mem[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (exp_we && (state != RUN)) begin
            for (int i = 0; i < VEC_LENGTH; i++) begin
                if (exp_addr == IDX_W'(i)) begin
                    mem[i] <= exp_data;
                end
            end
        end
    end

    assign handshake = resp_valid && resp_ready;
    assign mismatch  = (resp_data != exp_vec);
    assign misr_next = ({signature[OUT_WIDTH-2:0], 1'b0}
                        ^ (signature[OUT_WIDTH-1] ? MISR_POLY : '0)) ^ resp_data;
    assign pass      = done && (err_count == '0);

    always_ff @(posedge clk) begin
        if (rst || clear_run) begin
            idx             <= '0;
            err_count       <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
            signature       <= '0;
        end else if (handshake) begin
            idx       <= idx + 1'b1;
            signature <= misr_next;
            if (mismatch) begin
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
                if (!first_err_valid) begin
                    first_err_idx   <= idx;
                    first_err_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_response_checker.sv
// Directed bench for response_checker: table of per-handshake expectations plus
// hand-written sequences for gaps, aborts and ignored writes/starts.
module tb_response_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        exp_we;
    logic [15:0] exp_addr;
    logic [7:0]  exp_data;
    logic        start;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic        resp_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [15:0] first_err_idx;
    logic        first_err_valid;
    logic [7:0]  signature;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [7:0]  resp;
        logic [15:0] errCount;
        logic        firstValid;
        logic [15:0] firstIdx;
        logic [7:0]  sig;
        logic        done;
    } vecRec_t;

    vecRec_t vecTable[8];

    response_checker dut (
        .clk            (clk),
        .rst            (rst),
        .exp_we         (exp_we),
        .exp_addr       (exp_addr),
        .exp_data       (exp_data),
        .start          (start),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_ready     (resp_ready),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_idx  (first_err_idx),
        .first_err_valid(first_err_valid),
        .signature      (signature)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data);
        resp_valid = 1'b1;
        resp_data  = data;
        stepCycle();
        resp_valid = 1'b0;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        stepCycle();
        stepCycle();
        rst = 1'b0;
    endtask

    task automatic writeMem(input logic [15:0] addr, input logic [7:0] data);
        exp_we   = 1'b1;
        exp_addr = addr;
        exp_data = data;
        stepCycle();
        exp_we   = 1'b0;
    endtask

    task automatic startRun();
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        checkOutput("err_cleared", 32'(err_count), 32'd0);
        checkOutput("sig_cleared", 32'(signature), 32'd0);
        checkOutput("fv_cleared", 32'(first_err_valid), 32'd0);
    endtask

    task automatic runRows(input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            applyStimulus(vecTable[i].resp);
            checkOutput($sformatf("row%0d_err", i), 32'(err_count), 32'(vecTable[i].errCount));
            checkOutput($sformatf("row%0d_fv", i), 32'(first_err_valid), 32'(vecTable[i].firstValid));
            checkOutput($sformatf("row%0d_fidx", i), 32'(first_err_idx), 32'(vecTable[i].firstIdx));
            checkOutput($sformatf("row%0d_sig", i), 32'(signature), 32'(vecTable[i].sig));
            checkOutput($sformatf("row%0d_done", i), 32'(done), 32'(vecTable[i].done));
            checkOutput($sformatf("row%0d_pass", i), 32'(pass),
                        32'(vecTable[i].done && (vecTable[i].errCount == 16'd0)));
        end
    endtask

    initial begin
        // Good run A5,3C,00,FF then faulty run A5,3D,00,FE; signatures hand-computed.
        vecTable[0] = '{8'hA5, 16'd0, 1'b0, 16'd0, 8'hA5, 1'b0};
        vecTable[1] = '{8'h3C, 16'd0, 1'b0, 16'd0, 8'hCE, 1'b0};
        vecTable[2] = '{8'h00, 16'd0, 1'b0, 16'd0, 8'h24, 1'b0};
        vecTable[3] = '{8'hFF, 16'd0, 1'b0, 16'd0, 8'hB7, 1'b1};
        vecTable[4] = '{8'hA5, 16'd0, 1'b0, 16'd0, 8'hA5, 1'b0};
        vecTable[5] = '{8'h3D, 16'd1, 1'b1, 16'd1, 8'hCF, 1'b0};
        vecTable[6] = '{8'h00, 16'd1, 1'b1, 16'd1, 8'h26, 1'b0};
        vecTable[7] = '{8'hFE, 16'd2, 1'b1, 16'd1, 8'hB2, 1'b1};

        rst        = 1'b0;
        exp_we     = 1'b0;
        exp_addr   = '0;
        exp_data   = '0;
        start      = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        #1;

        $display("[TB] reset state");
        resetDut();
        checkOutput("rst_ready", 32'(resp_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass", 32'(pass), 32'd0);
        checkOutput("rst_err", 32'(err_count), 32'd0);
        checkOutput("rst_fidx", 32'(first_err_idx), 32'd0);
        checkOutput("rst_fv", 32'(first_err_valid), 32'd0);
        checkOutput("rst_sig", 32'(signature), 32'd0);

        $display("[TB] good run");
        writeMem(16'd0, 8'hA5);
        writeMem(16'd1, 8'h3C);
        writeMem(16'd2, 8'h00);
        writeMem(16'd3, 8'hFF);
        startRun();
        runRows(0, 4);

        $display("[TB] faulty run restarted from DONE");
        startRun();
        runRows(4, 4);

        $display("[TB] gap between vectors");
        startRun();
        runRows(0, 2);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("gap_ready", 32'(resp_ready), 32'd1);
            checkOutput("gap_sig", 32'(signature), 32'hCE);
        end
        runRows(2, 2);

        $display("[TB] resp_valid ignored in DONE and IDLE");
        resp_valid = 1'b1;
        resp_data  = 8'h5A;
        for (int i = 0; i < 2; i++) begin
            stepCycle();
            checkOutput("done_ready", 32'(resp_ready), 32'd0);
            checkOutput("done_hold", 32'(done), 32'd1);
            checkOutput("done_sig", 32'(signature), 32'hB7);
            checkOutput("done_err", 32'(err_count), 32'd0);
        end
        resp_valid = 1'b0;
        resetDut();
        resp_valid = 1'b1;
        stepCycle();
        stepCycle();
        resp_valid = 1'b0;
        checkOutput("idle_ready", 32'(resp_ready), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_sig", 32'(signature), 32'd0);

        $display("[TB] abort mid-run");
        startRun();
        runRows(4, 2);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_err", 32'(err_count), 32'd0);
        checkOutput("abort_fv", 32'(first_err_valid), 32'd0);
        checkOutput("abort_sig", 32'(signature), 32'd0);
        startRun();
        runRows(0, 4);

        $display("[TB] write and start during RUN");
        startRun();
        runRows(0, 1);
        exp_we   = 1'b1;
        exp_addr = 16'd1;
        exp_data = 8'h00;
        start    = 1'b1;
        stepCycle();
        exp_we   = 1'b0;
        start    = 1'b0;
        checkOutput("run_start_busy", 32'(busy), 32'd1);
        checkOutput("run_start_sig", 32'(signature), 32'hA5);
        runRows(1, 3);

        $display("[TB] simultaneous rst and start");
        rst   = 1'b1;
        start = 1'b1;
        stepCycle();
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("rst_start_busy", 32'(busy), 32'd0);
        checkOutput("rst_start_done", 32'(done), 32'd0);

        $display("[TB] out-of-range write ignored");
        writeMem(16'd4, 8'h00);
        startRun();
        runRows(0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
